// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Purpose  : Data-side load/store responder: word RAM plus an MMIO window
//            holding a cycle counter, a tohost completion register and a
//            scratch register.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        done,
    output logic [31:0] done_code,
    output logic [31:0] cycle_count
);

    localparam int          c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] c_CNT_ADDR  = MMIO_BASE;
    localparam logic [31:0] c_TOHOST    = MMIO_BASE + 32'h4;
    localparam logic [31:0] c_SCRATCH   = MMIO_BASE + 32'h8;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_MMIO_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_pend_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_scratch;
    logic [31:0] r_cnt;
    logic        r_done;
    logic [31:0] r_done_code;

    logic            w_accept;
    logic            w_misaligned;
    logic            w_is_ram;
    logic            w_is_cnt;
    logic            w_is_tohost;
    logic            w_is_scratch;
    logic            w_is_mmio;
    logic            w_err;
    logic            w_wr;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_rd_data;

    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [3:0]  strb);
        logic [31:0] v;
        v = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                v[8*i +: 8] = wd[8*i +: 8];
            end
        end
        return v;
    endfunction

    // Address decode, evaluated in priority order: alignment first.
    always_comb begin
        w_accept     = req_valid && r_ready;
        w_misaligned = |req_addr[1:0];
        w_is_ram     = !w_misaligned && (req_addr < c_RAM_BYTES);
        w_is_cnt     = (req_addr == c_CNT_ADDR);
        w_is_tohost  = (req_addr == c_TOHOST);
        w_is_scratch = (req_addr == c_SCRATCH);
        w_is_mmio    = w_is_cnt || w_is_tohost || w_is_scratch;
        w_err        = w_misaligned || (w_is_cnt && req_we) ||
                       !(w_is_ram || w_is_mmio);
        w_wr         = w_accept && req_we && !w_err;
        w_idx        = req_addr[c_AW+1:2];
        w_rd_data    = 32'h0;
        if (!req_we) begin
            if (w_is_ram) begin
                w_rd_data = r_mem[w_idx];
            end else if (w_is_cnt) begin
                w_rd_data = r_cnt;
            end else if (w_is_tohost) begin
                w_rd_data = r_done_code;
            end else if (w_is_scratch) begin
                w_rd_data = r_scratch;
            end
        end
    end

    // Handshake FSM. MMIO data is captured at accept and released one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'h0;
            r_pend_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'h0;
                    if (w_accept) begin
                        if (w_err) begin
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_is_mmio) begin
                            r_state      <= ST_MMIO_WAIT;
                            r_ready      <= 1'b0;
                            r_pend_rdata <= w_rd_data;
                        end else begin
                            r_valid <= 1'b1;
                            r_rdata <= w_rd_data;
                        end
                    end
                end
                ST_MMIO_WAIT: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b1;
                    r_err   <= 1'b0;
                    r_rdata <= r_pend_rdata;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_wr && w_is_ram) begin
            r_mem[w_idx] <= f_merge(r_mem[w_idx], req_wdata, req_wstrb);
        end
    end

    // First tohost write wins; later writes are acknowledged but ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 32'h0;
            r_scratch   <= 32'h0;
            r_done      <= 1'b0;
            r_done_code <= 32'h0;
        end else begin
            r_cnt <= r_cnt + 32'h1;
            if (w_wr && w_is_scratch) begin
                r_scratch <= f_merge(r_scratch, req_wdata, req_wstrb);
            end
            if (w_wr && w_is_tohost && !r_done) begin
                r_done      <= 1'b1;
                r_done_code <= req_wdata;
            end
        end
    end

    assign req_ready   = r_ready;
    assign resp_valid  = r_valid;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign done        = r_done;
    assign done_code   = r_done_code;
    assign cycle_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio_responder
// Purpose  : Scoreboard bench for dmem_mmio_responder with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

    localparam logic [31:0] c_MB = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        done;
    logic [31:0] done_code;
    logic [31:0] cycle_count;

    dmem_mmio_responder #(
        .DEPTH_WORDS(64),
        .MMIO_BASE  (c_MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .done       (done),
        .done_code  (done_code),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tb_cyc = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) tb_cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (mon_en) begin
            if (resp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: rdata %h err %b at cycle %0d",
                             resp_rdata, resp_err, tb_cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err || tb_cyc != e.due) begin
                        errors++;
                        $display("FAIL resp: got rdata %h err %b cycle %0d expected rdata %h err %b cycle %0d",
                                 resp_rdata, resp_err, tb_cyc, e.rdata, e.err, e.due);
                    end
                end
            end else begin
                checks++;
                if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_resp: valid %b rdata %h err %b expected 0 0 0",
                             resp_valid, resp_rdata, resp_err);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat);
        int   tries;
        exp_t e;
        tries = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready %b expected 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.due     = tb_cyc + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wstrb = 4'h0;
        if (lat == 2) begin
            @(negedge clk);
            chk("ready_low_mmio", {31'h0, req_ready}, 32'h0);
        end
    endtask

    initial begin
        int t0;
        // Test 1: reset and idle
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst    = 1'b0;
        t0     = tb_cyc;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_done_code", done_code, 32'h0);
        chk("rst_cnt", cycle_count, 32'h0);
        repeat (9) @(negedge clk);
        chk("idle_cnt9", cycle_count, 32'd9);
        chk("idle_ready", {31'h0, req_ready}, 32'h1);
        chk("idle_done", {31'h0, done}, 32'h0);

        // Test 2: RAM full write, byte-strobe write, read back (back-to-back)
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 1);
        issue(1'b1, 32'h10, 32'h0000_5500, 4'b0010, 32'h0, 1'b0, 1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_55EF, 1'b0, 1);

        // Test 3: counter read accepted when count is 20, counter write faults
        while (tb_cyc - t0 != 19) @(negedge clk);
        issue(1'b0, c_MB, 32'h0, 4'h0, 32'd20, 1'b0, 2);
        issue(1'b1, c_MB, 32'h1234, 4'hF, 32'h0, 1'b1, 1);

        // Test 4: tohost, first code wins
        issue(1'b1, c_MB + 32'h4, 32'h1, 4'h0, 32'h0, 1'b0, 2);
        chk("done_set", {31'h0, done}, 32'h1);
        chk("done_code1", done_code, 32'h1);
        issue(1'b1, c_MB + 32'h4, 32'h2, 4'hF, 32'h0, 1'b0, 2);
        chk("done_code_sticky", done_code, 32'h1);
        issue(1'b0, c_MB + 32'h4, 32'h0, 4'h0, 32'h1, 1'b0, 2);

        // Scratch with partial and zero strobes
        issue(1'b1, c_MB + 32'h8, 32'hA5A5_1234, 4'b1100, 32'h0, 1'b0, 2);
        issue(1'b1, c_MB + 32'h8, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 2);
        issue(1'b0, c_MB + 32'h8, 32'h0, 4'h0, 32'hA5A5_0000, 1'b0, 2);

        // Test 5: faults and RAM boundary
        issue(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        issue(1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        issue(1'b0, c_MB + 32'hC, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1);
        issue(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1);
        issue(1'b1, c_MB + 32'hA, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_55EF, 1'b0, 1);
        issue(1'b0, c_MB + 32'h8, 32'h0, 4'h0, 32'hA5A5_0000, 1'b0, 2);
        issue(1'b1, 32'hFC, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1);
        issue(1'b0, 32'hFC, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1);
        chk("done_after_faults", done_code, 32'h1);

        // Test 6: reset during MMIO_WAIT discards the pending response
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = c_MB + 32'h8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        chk("wait_ready_low", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t0  = tb_cyc;
        chk("rst2_ready", {31'h0, req_ready}, 32'h1);
        chk("rst2_done", {31'h0, done}, 32'h0);
        chk("rst2_done_code", done_code, 32'h0);
        chk("rst2_cnt", cycle_count, 32'h0);
        issue(1'b0, c_MB, 32'h0, 4'h0, 32'd1, 1'b0, 2);
        issue(1'b0, c_MB + 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 2);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1);
        issue(1'b0, 32'hFC, 32'h0, 4'h0, 32'h0, 1'b0, 1);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
